// File: rtl/dcache_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dcache_pkg                                                       |
// | Shared encodings and field-width helpers for the data cache.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package dcache_pkg;

  localparam logic [1:0] TC_WORD = 2'b00;
  localparam logic [1:0] TC_BYTE = 2'b01;
  localparam logic [1:0] TC_HALF = 2'b10;

  localparam int OFFSET_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Address field width; zero when the field collapses (single line/word).
  function automatic int field_w(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  // Storage width for a field index; never narrower than one bit.
  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_align                                                        |
// | Byte-lane selection, load extension and store lane placement.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module lsu_align
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]              type_control_i,
  input  logic                    sign_ext_i,
  input  logic [1:0]              offset_i,
  input  logic [DATA_WIDTH-1:0]   load_word_i,
  input  logic [DATA_WIDTH-1:0]   store_data_i,
  output logic [DATA_WIDTH-1:0]   load_data_o,
  output logic [DATA_WIDTH-1:0]   store_word_o,
  output logic [DATA_WIDTH/8-1:0] store_strb_o
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  assign byte_w = load_word_i[{offset_i, 3'b000} +: 8];
  assign half_w = load_word_i[{offset_i[1], 4'b0000} +: 16];

  // Store data is replicated into every lane; the strobe picks the live one.
  always_comb begin
    load_data_o  = load_word_i;
    store_word_o = store_data_i;
    store_strb_o = '1;
    case (type_control_i)
      TC_BYTE: begin
        load_data_o  = {{(DATA_WIDTH-8){sign_ext_i & byte_w[7]}}, byte_w};
        store_word_o = {STRB_W{store_data_i[7:0]}};
        store_strb_o = STRB_W'(1) << offset_i;
      end
      TC_HALF: begin
        load_data_o  = {{(DATA_WIDTH-16){sign_ext_i & half_w[15]}}, half_w};
        store_word_o = {(STRB_W/2){store_data_i[15:0]}};
        store_strb_o = STRB_W'(3) << {offset_i[1], 1'b0};
      end
      TC_WORD: begin
        load_data_o  = load_word_i;
        store_word_o = store_data_i;
        store_strb_o = '1;
      end
      default: begin
        load_data_o  = load_word_i;
        store_word_o = store_data_i;
        store_strb_o = '1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// +------------------------------------------------------------------+
// | data_cache                                                       |
// | Direct-mapped, write-through, no-write-allocate data cache.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module data_cache
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [1:0]            type_control,
  input  logic                  sign_ext_flag,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int WI_W     = field_w(WORDS_PER_LINE);
  localparam int IX_W     = field_w(NUM_LINES);
  localparam int CNT_W    = slot_w(WORDS_PER_LINE);
  localparam int LN_W     = slot_w(NUM_LINES);
  localparam int LINE_LSB = OFFSET_W + WI_W;
  localparam int TAG_LSB  = LINE_LSB + IX_W;
  localparam int TAG_W    = DATA_WIDTH - TAG_LSB;
  localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [DATA_WIDTH-1:0] LINE_MASK = DATA_WIDTH'(WORDS_PER_LINE * 4 - 1);

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [LN_W-1:0]       line_q;
  logic [CNT_W-1:0]      word_q;
  logic [TAG_W-1:0]      req_tag_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [DATA_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [3:0]            mem_wstrb_q;
  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_W-1:0]      line_tag_q [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_q     [NUM_LINES][WORDS_PER_LINE];

  logic [LN_W-1:0]       line_w;
  logic [CNT_W-1:0]      word_w;
  logic [TAG_W-1:0]      tag_w;
  logic                  hit_w;
  logic                  store_hit_w;
  logic                  xfer_done_w;
  logic [DATA_WIDTH-1:0] load_w;
  logic [DATA_WIDTH-1:0] st_word_w;
  logic [3:0]            st_strb_w;
  logic [DATA_WIDTH-1:0] cur_word_w;
  logic [DATA_WIDTH-1:0] merged_w;

  assign line_w = (NUM_LINES > 1)      ? LN_W'(addr >> LINE_LSB)  : '0;
  assign word_w = (WORDS_PER_LINE > 1) ? CNT_W'(addr >> OFFSET_W) : '0;
  assign tag_w  = TAG_W'(addr >> TAG_LSB);

  assign hit_w       = valid_q[line_w] && (line_tag_q[line_w] == tag_w);
  assign store_hit_w = valid_q[line_q] && (line_tag_q[line_q] == req_tag_q);
  assign xfer_done_w = mem_req_q && mem_ack;

  lsu_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .type_control_i (type_control),
    .sign_ext_i     (sign_ext_flag),
    .offset_i       (addr[1:0]),
    .load_word_i    (data_q[line_w][word_w]),
    .store_data_i   (wdata),
    .load_data_o    (load_w),
    .store_word_o   (st_word_w),
    .store_strb_o   (st_strb_w)
  );

  assign rdata = (state_q == IDLE && req_valid && !req_write && hit_w) ? load_w : '0;

  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE:        stall = req_valid && (req_write || !hit_w);
      FILL, WRITE: stall = 1'b1;
      default:     stall = 1'b0;
    endcase
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

  // The line is invalidated when a fill starts, so an aborted fill never hits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      line_q      <= '0;
      word_q      <= '0;
      req_tag_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      valid_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            line_q    <= line_w;
            word_q    <= word_w;
            req_tag_q <= tag_w;
            if (req_write) begin
              state_q     <= WRITE;
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {addr[DATA_WIDTH-1:2], 2'b00};
              mem_wdata_q <= st_word_w;
              mem_wstrb_q <= st_strb_w;
            end else if (!hit_w) begin
              state_q         <= FILL;
              cnt_q           <= '0;
              mem_req_q       <= 1'b1;
              mem_we_q        <= 1'b0;
              mem_addr_q      <= addr & ~LINE_MASK;
              valid_q[line_w] <= 1'b0;
            end
          end
        end
        FILL: begin
          if (xfer_done_w) begin
            if (cnt_q == LAST_CNT) begin
              state_q         <= IDLE;
              cnt_q           <= '0;
              mem_req_q       <= 1'b0;
              valid_q[line_q] <= 1'b1;
            end else begin
              cnt_q      <= cnt_q + 1'b1;
              mem_addr_q <= mem_addr_q + DATA_WIDTH'(4);
            end
          end
        end
        WRITE: begin
          if (xfer_done_w) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cur_word_w = data_q[line_q][word_q];

  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign merged_w[8*b +: 8] = mem_wstrb_q[b] ? mem_wdata_q[8*b +: 8] : cur_word_w[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (!rst && xfer_done_w) begin
      if (state_q == FILL) begin
        data_q[line_q][cnt_q] <= mem_rdata;
        if (cnt_q == LAST_CNT) begin
          line_tag_q[line_q] <= req_tag_q;
        end
      end else if (state_q == WRITE && store_hit_w) begin
        data_q[line_q][word_q] <= merged_w;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_data_cache                                                    |
// | Scoreboard bench: RAM model, reference cache model, monitor.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_data_cache;

  localparam int NL  = 16;
  localparam int WPL = 4;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_write, sign_ext_flag;
  logic [1:0]  type_control;
  logic [31:0] addr, wdata, rdata;
  logic        stall, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  data_cache #(
    .DATA_WIDTH     (32),
    .NUM_LINES      (NL),
    .WORDS_PER_LINE (WPL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .type_control  (type_control),
    .sign_ext_flag (sign_ext_flag),
    .addr          (addr),
    .wdata         (wdata),
    .rdata         (rdata),
    .stall         (stall),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata)
  );

  typedef struct {
    logic        is_load;
    logic [31:0] data;
    int          stalls;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } xfer_t;

  int          total = 0;
  int          bad   = 0;
  exp_t        eq[$];
  xfer_t       xq[$];
  logic [31:0] ram [logic [31:0]];
  bit          mv [NL];
  int          mt [NL];
  int          ram_lat = 1;
  int          wcnt = 0;
  int          sc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [1:0] tc,
                                           input logic sx, input logic [1:0] off);
    logic [31:0] v;
    if (tc == 2'b01) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (sx && v[7]) v = v | 32'hFFFF_FF00;
    end else if (tc == 2'b10) begin
      v = (w >> (16 * off[1])) & 32'hFFFF;
      if (sx && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // Backing RAM: ram_lat cycles of mem_req per transfer, ack on the last one.
  initial begin : ram_model
    xfer_t x;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end
      if (mem_req && !rst) begin
        wcnt++;
        if (wcnt >= ram_lat) begin
          if (xq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL xfer_unexpected: got addr %h want no transfer", mem_addr);
          end else begin
            x = xq.pop_front();
            chk("xfer_we", 32'(mem_we), 32'(x.we));
            chk("xfer_addr", mem_addr, x.addr);
            if (x.we) begin
              chk("xfer_strb", 32'(mem_wstrb), 32'(x.strb));
              chk("xfer_wdata", mem_wdata & lane_mask(x.strb), x.data);
              ram[x.addr] = (ram_rd(x.addr) & ~lane_mask(x.strb)) | x.data;
            end else begin
              mem_rdata = ram_rd(x.addr);
            end
          end
          mem_ack = 1'b1;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: a request completes on the first non-stalled cycle it is held.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sc = 0;
      end else if (req_valid) begin
        if (stall) begin
          sc++;
        end else begin
          if (eq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL resp_unexpected: got completion want none");
          end else begin
            e = eq.pop_front();
            chk("stall_cycles", sc, e.stalls);
            if (e.is_load) chk("rdata", rdata, e.data);
          end
          sc = 0;
        end
      end
    end
  end

  task automatic expect_req(input logic wr, input logic [1:0] tc, input logic sx,
                            input logic [31:0] a, input logic [31:0] wd, input int lat);
    int    line, tag;
    exp_t  e;
    xfer_t x;
    line      = int'((a / (WPL * 4)) % NL);
    tag       = int'(a / (WPL * 4 * NL));
    e.is_load = !wr;
    e.data    = '0;
    if (wr) begin
      x.we   = 1'b1;
      x.addr = a & ~32'h3;
      case (tc)
        2'b01: begin
          x.strb = 4'b0001 << a[1:0];
          x.data = {24'h0, wd[7:0]} << (8 * a[1:0]);
        end
        2'b10: begin
          x.strb = 4'b0011 << (2 * a[1]);
          x.data = {16'h0, wd[15:0]} << (16 * a[1]);
        end
        default: begin
          x.strb = 4'hF;
          x.data = wd;
        end
      endcase
      xq.push_back(x);
      e.stalls = 1 + lat;
    end else begin
      e.data = ext_load(ram_rd(a & ~32'h3), tc, sx, a[1:0]);
      if (mv[line] && mt[line] == tag) begin
        e.stalls = 0;
      end else begin
        for (int i = 0; i < WPL; i++) begin
          x.we   = 1'b0;
          x.addr = (a & ~32'(WPL * 4 - 1)) + 32'(4 * i);
          x.strb = '0;
          x.data = '0;
          xq.push_back(x);
        end
        e.stalls = 1 + WPL * lat;
        mv[line] = 1'b1;
        mt[line] = tag;
      end
    end
    eq.push_back(e);
  endtask

  task automatic drive(input logic wr, input logic [1:0] tc, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid     = 1'b1;
    req_write     = wr;
    type_control  = tc;
    sign_ext_flag = sx;
    addr          = a;
    wdata         = wd;
  endtask

  // Called and returns at posedge+1; holds the request until stall drops.
  task automatic do_req(input logic wr, input logic [1:0] tc, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input int lat);
    int guard;
    ram_lat = lat;
    expect_req(wr, tc, sx, a, wd, lat);
    drive(wr, tc, sx, a, wd);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (stall && guard < 200);
    if (stall) begin
      total++;
      bad++;
      $display("FAIL req_timeout: got stall=1 after %0d cycles want completion", guard);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int acks, guard;
    rst           = 1'b1;
    req_valid     = 1'b0;
    req_write     = 1'b0;
    type_control  = 2'b00;
    sign_ext_flag = 1'b0;
    addr          = '0;
    wdata         = '0;
    for (int i = 0; i < NL; i++) begin
      mv[i] = 1'b0;
      mt[i] = 0;
    end
    ram[32'h100] = 32'h11;
    ram[32'h104] = 32'h22;
    ram[32'h108] = 32'h33;
    ram[32'h10C] = 32'h44;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    @(posedge clk);
    #1;

    // Cold fill, hit, byte store, merged reads, extensions.
    do_req(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 2);
    do_req(1'b0, 2'b00, 1'b0, 32'h108, 32'h0, 2);
    do_req(1'b1, 2'b01, 1'b0, 32'h101, 32'hAB, 2);
    do_req(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 2);
    do_req(1'b0, 2'b01, 1'b1, 32'h101, 32'h0, 2);
    do_req(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 2);
    do_req(1'b1, 2'b10, 1'b0, 32'h102, 32'h8001, 1);
    do_req(1'b0, 2'b10, 1'b1, 32'h102, 32'h0, 1);
    do_req(1'b0, 2'b11, 1'b0, 32'h103, 32'h0, 1);

    // Uncached store, then conflicting fills on line 0.
    do_req(1'b1, 2'b00, 1'b0, 32'h400, 32'hCAFE_F00D, 3);
    do_req(1'b0, 2'b00, 1'b0, 32'h400, 32'h0, 1);
    do_req(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 1);
    do_req(1'b0, 2'b00, 1'b0, 32'h200, 32'h0, 2);
    do_req(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 1);

    // Reset after the second ack of a fill.
    ram_lat = 2;
    for (int i = 0; i < WPL; i++) xq.push_back('{1'b0, 32'h300 + 32'(4 * i), 4'h0, 32'h0});
    drive(1'b0, 2'b00, 1'b0, 32'h300, 32'h0);
    acks  = 0;
    guard = 0;
    while (acks < 2 && guard < 100) begin
      @(posedge clk);
      guard++;
      if (mem_ack) acks++;
    end
    chk("abort_acks_seen", 32'(acks), 32'd2);
    #1;
    rst       = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_stall", 32'(stall), 32'd0);
    xq.delete();
    for (int i = 0; i < NL; i++) mv[i] = 1'b0;
    @(posedge clk);
    #1;
    do_req(1'b0, 2'b00, 1'b0, 32'h300, 32'h0, 2);
    do_req(1'b0, 2'b00, 1'b0, 32'h30C, 32'h0, 2);

    // Randomized mix over a few lines and eight aliasing tags.
    for (int n = 0; n < 120; n++) begin
      logic        wr;
      logic [31:0] a;
      wr = ($urandom_range(0, 9) < 3);
      a  = (32'($urandom_range(0, 7)) << 8) + 32'($urandom_range(0, 63));
      do_req(wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom,
             $urandom_range(1, 3));
    end

    repeat (3) @(negedge clk);
    chk("pending_responses", 32'(eq.size()), 32'd0);
    chk("pending_transfers", 32'(xq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
